// File: rtl/bin_to_bcd_converter_if.sv
// Request/result bundle for the binary-to-BCD converter.
// Purely structural: no latency of its own.
// The converter ignores start while busy is high.
interface bin_to_bcd_converter_if #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
);
    logic                  start;
    logic [WIDTH-1:0]      value;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
    logic [DIGITS-1:0]     digit_en;
    logic                  overflow;

    // Requester side: issues start/value, observes status and result.
    modport master (
        output start,
        output value,
        input  busy,
        input  done,
        input  bcd,
        input  digit_en,
        input  overflow
    );

    // Converter side.
    modport slave (
        input  start,
        input  value,
        output busy,
        output done,
        output bcd,
        output digit_en,
        output overflow
    );
endinterface

// File: rtl/bin_to_bcd_converter.sv
// Iterative double-dabble binary-to-BCD converter with display blanking mask.
// Latency: WIDTH cycles from accepted start to done; back-to-back every WIDTH+1 cycles.
// No backpressure: start is ignored while busy and is not queued.
module bin_to_bcd_converter #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                 clk,
    input  logic                 reset_n,
    bin_to_bcd_converter_if.slave bus
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int BW = 4 * DIGITS;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t state;
    state_t state_nxt;

    // Working registers: operand being consumed MSB first, partial BCD,
    // iteration count and the sticky "a bit fell off the top digit" flag.
    logic [WIDTH-1:0]  shreg;
    logic [BW-1:0]     work;
    logic [CW-1:0]     iter;
    logic              ovf_pend;

    // Result registers; only updated on the final iteration so the
    // displays never see partial values.
    logic [BW-1:0]     bcd_q;
    logic [DIGITS-1:0] digit_en_q;
    logic              overflow_q;
    logic              done_q;

    // One-iteration datapath.
    logic [BW-1:0]     adj;
    logic [BW-1:0]     work_nxt;
    logic [WIDTH-1:0]  shreg_nxt;
    logic              ovf_nxt;
    logic [DIGITS-1:0] en_nxt;
    logic              last_iter;
    logic              accept;
    logic              any_nz;

    // Add 3 to every digit that is 5 or more so the following doubling
    // carries correctly into the next decimal digit.
    always_comb begin
        adj = work;
        for (int k = 0; k < DIGITS; k++) begin
            if (work[4*k +: 4] >= 4'd5) begin
                adj[4*k +: 4] = work[4*k +: 4] + 4'd3;
            end
        end
    end

    // Shift {BCD, operand} left by one; the bit leaving the top digit means
    // the value needs more digits than we have, so latch it as overflow.
    always_comb begin
        {work_nxt, shreg_nxt} = {adj[BW-2:0], shreg, 1'b0};
        ovf_nxt               = ovf_pend | adj[BW-1];
    end

    // Leading-zero mask: a digit is lit if it or any more significant digit
    // is nonzero; the units digit is always lit.
    always_comb begin
        en_nxt = '0;
        any_nz = 1'b0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            any_nz    = any_nz | (work_nxt[4*k +: 4] != 4'd0);
            en_nxt[k] = any_nz;
        end
        en_nxt[0] = 1'b1;
    end

    // The counter tops out at WIDTH-1, so it never wraps inside a conversion.
    assign last_iter = (iter == CW'(WIDTH - 1));

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: accept start only in IDLE, leave SHIFT after WIDTH iterations.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    accept    = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (last_iter) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Working datapath: capture on accept, iterate while shifting.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shreg    <= '0;
            work     <= '0;
            iter     <= '0;
            ovf_pend <= 1'b0;
        end else if (accept) begin
            shreg    <= bus.value;
            work     <= '0;
            iter     <= '0;
            ovf_pend <= 1'b0;
        end else if (state == SHIFT) begin
            shreg    <= shreg_nxt;
            work     <= work_nxt;
            ovf_pend <= ovf_nxt;
            if (!last_iter) begin
                iter <= iter + 1'b1;
            end
        end
    end

    // Result registers and done pulse, loaded straight from the final iteration.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bcd_q      <= '0;
            digit_en_q <= DIGITS'(1);
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state == SHIFT && last_iter) begin
                bcd_q      <= work_nxt;
                digit_en_q <= en_nxt;
                overflow_q <= ovf_nxt;
                done_q     <= 1'b1;
            end
        end
    end

    assign bus.busy     = (state == SHIFT);
    assign bus.done     = done_q;
    assign bus.bcd      = bcd_q;
    assign bus.digit_en = digit_en_q;
    assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_bin_to_bcd_converter.sv
// Self-checking bench for bin_to_bcd_converter: 5-digit and 4-digit builds.
// Inputs driven and outputs sampled on the falling clock edge.
// Table vectors, directed corner cases and random values against an arithmetic model.
module tb_bin_to_bcd_converter;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int last_done_cyc = 0;

    always @(posedge clk) cyc++;

    bin_to_bcd_converter_if #(.WIDTH(16), .DIGITS(5)) bus5 ();
    bin_to_bcd_converter_if #(.WIDTH(16), .DIGITS(4)) bus4 ();

    bin_to_bcd_converter #(.WIDTH(16), .DIGITS(5)) dut5 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus5)
    );

    bin_to_bcd_converter #(.WIDTH(16), .DIGITS(4)) dut4 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus4)
    );

    typedef struct {
        logic [15:0] value;
        logic [19:0] bcd;
        logic [4:0]  en;
        logic        ovf;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // Reference: decimal digits by division, overflow by magnitude comparison.
    function automatic void model(input int v, input int nd, output logic [19:0] b,
                                  output logic [4:0] en, output logic ovf);
        int lim;
        int r;
        int p;
        lim = 1;
        for (int k = 0; k < nd; k++) lim *= 10;
        ovf = (v >= lim);
        b   = '0;
        en  = '0;
        r   = v % lim;
        p   = 1;
        for (int k = 0; k < nd; k++) begin
            b[4*k +: 4] = 4'((r / p) % 10);
            en[k]       = (k == 0) || ((r / p) != 0);
            p *= 10;
        end
    endfunction

    // Starts a conversion at the next rising edge (edge N) and returns at the
    // sample just after edge N+16, where done must be high. extra_edge > 0
    // raises start again so that it is seen at edge N+extra_edge.
    task automatic convert(input logic [15:0] v, input int extra_edge, input string tag);
        logic [19:0] eb;
        logic [4:0]  een;
        logic        eo;
        logic [19:0] pb;
        model(int'(v), 5, eb, een, eo);
        pb = bus5.bcd;
        bus5.start = 1'b1;
        bus5.value = v;
        @(negedge clk);
        bus5.start = 1'b0;
        bus5.value = 16'($urandom);
        for (int i = 0; i < 16; i++) begin
            check({tag, " busy/done"}, {30'd0, bus5.busy, bus5.done}, 32'b10);
            check({tag, " hold"}, bus5.bcd, pb);
            bus5.start = (extra_edge > 0) && (i == extra_edge - 1);
            @(negedge clk);
        end
        bus5.start = 1'b0;
        check({tag, " done"}, {30'd0, bus5.busy, bus5.done}, 32'b01);
        check({tag, " bcd"}, bus5.bcd, eb);
        check({tag, " en"}, bus5.digit_en, een);
        check({tag, " ovf"}, bus5.overflow, eo);
        last_done_cyc = cyc;
    endtask

    // Same for the 4-digit build, with a bounded wait for done.
    task automatic conv4(input logic [15:0] v, input string tag);
        logic [19:0] eb;
        logic [4:0]  een;
        logic        eo;
        int          n;
        model(int'(v), 4, eb, een, eo);
        bus4.start = 1'b1;
        bus4.value = v;
        @(negedge clk);
        bus4.start = 1'b0;
        n = 0;
        while (!bus4.done && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, " done"}, bus4.done, 1);
        check({tag, " bcd"}, bus4.bcd, eb[15:0]);
        check({tag, " en"}, bus4.digit_en, een[3:0]);
        check({tag, " ovf"}, bus4.overflow, eo);
        @(negedge clk);
    endtask

    initial begin
        int t1;
        int dones;
        logic [15:0] rv;

        vecs[0] = '{16'd0,     20'h00000, 5'b00001, 1'b0};
        vecs[1] = '{16'd65535, 20'h65535, 5'b11111, 1'b0};
        vecs[2] = '{16'd9,     20'h00009, 5'b00001, 1'b0};
        vecs[3] = '{16'd10,    20'h00010, 5'b00011, 1'b0};
        vecs[4] = '{16'd42,    20'h00042, 5'b00011, 1'b0};
        vecs[5] = '{16'd1000,  20'h01000, 5'b01111, 1'b0};
        vecs[6] = '{16'd10000, 20'h10000, 5'b11111, 1'b0};
        vecs[7] = '{16'd50505, 20'h50505, 5'b11111, 1'b0};

        reset_n    = 1'b0;
        bus5.start = 1'b0;
        bus5.value = '0;
        bus4.start = 1'b0;
        bus4.value = '0;
        repeat (3) @(negedge clk);
        check("rst busy/done", {30'd0, bus5.busy, bus5.done}, 0);
        check("rst bcd", bus5.bcd, 0);
        check("rst en", bus5.digit_en, 5'b00001);
        check("rst ovf", bus5.overflow, 0);
        check("rst4 en", bus4.digit_en, 4'b0001);
        reset_n = 1'b1;
        @(negedge clk);

        // Zero: exact busy window and done timing.
        convert(16'd0, 0, "zero");
        @(negedge clk);
        check("zero done clears", {30'd0, bus5.busy, bus5.done}, 0);

        convert(16'd65535, 0, "max");
        check("max bcd const", bus5.bcd, 20'h65535);
        check("max en const", bus5.digit_en, 5'b11111);
        @(negedge clk);

        // Second start during the conversion must be dropped, not queued.
        convert(16'd1234, 5, "ignored_start");
        check("1234 bcd const", bus5.bcd, 20'h01234);
        check("1234 en const", bus5.digit_en, 5'b01111);
        @(negedge clk);
        check("no queued start", {30'd0, bus5.busy, bus5.done}, 0);
        repeat (3) @(negedge clk);
        check("still idle", {30'd0, bus5.busy, bus5.done}, 0);

        // Back-to-back: second start issued in the done cycle.
        convert(16'd42, 0, "b2b first");
        t1 = last_done_cyc;
        convert(16'd9, 0, "b2b second");
        check("b2b spacing", last_done_cyc - t1, 17);
        check("b2b bcd const", bus5.bcd, 20'h00009);
        check("b2b en const", bus5.digit_en, 5'b00001);
        @(negedge clk);

        // Hand-computed table.
        foreach (vecs[i]) begin
            convert(vecs[i].value, 0, "table");
            check("table bcd", bus5.bcd, vecs[i].bcd);
            check("table en", bus5.digit_en, vecs[i].en);
            check("table ovf", bus5.overflow, vecs[i].ovf);
        end
        @(negedge clk);

        // Random values against the model, back-to-back and spaced.
        for (int i = 0; i < 30; i++) begin
            rv = 16'($urandom_range(0, 65535));
            convert(rv, 0, "random");
            if (i % 3 == 0) repeat (int'($urandom_range(1, 3))) @(negedge clk);
        end
        @(negedge clk);

        // Reset in the middle of a conversion of 999, asserted before edge N+8.
        bus5.start = 1'b1;
        bus5.value = 16'd999;
        @(negedge clk);
        bus5.start = 1'b0;
        repeat (7) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("midrst busy/done", {30'd0, bus5.busy, bus5.done}, 0);
        check("midrst bcd", bus5.bcd, 0);
        check("midrst en", bus5.digit_en, 5'b00001);
        check("midrst ovf", bus5.overflow, 0);
        @(negedge clk);
        reset_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus5.done || bus5.busy) dones++;
        end
        check("midrst no activity", dones, 0);
        check("midrst bcd held", bus5.bcd, 0);
        convert(16'd999, 0, "after reset");
        check("999 bcd const", bus5.bcd, 20'h00999);
        @(negedge clk);

        // Four-digit build: overflow boundary.
        conv4(16'd12345, "d4 12345");
        check("d4 12345 bcd const", bus4.bcd, 16'h2345);
        check("d4 12345 ovf const", bus4.overflow, 1);
        conv4(16'd9999, "d4 9999");
        conv4(16'd10000, "d4 10000");
        for (int i = 0; i < 6; i++) begin
            conv4(16'($urandom_range(0, 65535)), "d4 random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
